// File: rtl/pito_test_monitor.sv
// End-of-test monitor for the multi-hart pito core: watches stores to tohost,
// records per-hart pass/fail with the riscv-tests encoding, and bounds the run
// with a cycle-count timeout.
module pito_test_monitor #(
  parameter int unsigned     NUM_HARTS      = 8,
  parameter int unsigned     XLEN           = 32,
  parameter logic [XLEN-1:0] TOHOST_ADDR    = 'h0000_1000,
  parameter int unsigned     TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned     CNT_W          = 32,
  localparam int unsigned    HID_W          = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 clear,
  input  logic                 wr_en,
  input  logic [HID_W-1:0]     wr_hart,
  input  logic [XLEN-1:0]      wr_addr,
  input  logic [XLEN-1:0]      wr_data,
  input  logic [HID_W-1:0]     rd_hart,
  output logic [XLEN-2:0]      rd_code,
  output logic [NUM_HARTS-1:0] hart_done,
  output logic [NUM_HARTS-1:0] hart_fail,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [CNT_W-1:0]     cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE,
    S_TIMEOUT
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [XLEN-1:0]  PASS_WORD = XLEN'(1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_HARTS-1:0] done_q, done_d;
  logic [NUM_HARTS-1:0] fail_q, fail_d;
  logic [XLEN-2:0]      code_q [NUM_HARTS];
  logic [XLEN-2:0]      code_d [NUM_HARTS];
  logic [XLEN-2:0]      rd_code_q, rd_code_d;
  logic                 store_ok;
  logic                 is_fail;
  logic [NUM_HARTS-1:0] hit;

  // Qualify the tohost store; hit is one-hot on the hart it completes, and
  // stays empty for out-of-range harts or harts that already finished.
  always_comb begin
    store_ok = (state_q == S_RUN) && wr_en && (wr_addr == TOHOST_ADDR) && wr_data[0];
    is_fail  = (wr_data != PASS_WORD);
    hit      = '0;
    for (int unsigned i = 0; i < NUM_HARTS; i++) begin
      hit[i] = store_ok && (wr_hart == HID_W'(i)) && !done_q[i];
    end
  end

  // Next-state logic for the run FSM, counters, flags, codes and read-back.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    fail_d    = fail_q;
    code_d    = code_q;
    rd_code_d = '0;
    for (int unsigned i = 0; i < NUM_HARTS; i++) begin
      if (rd_hart == HID_W'(i)) rd_code_d = code_q[i];
    end
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          done_d  = '0;
          fail_d  = '0;
          for (int unsigned i = 0; i < NUM_HARTS; i++) code_d[i] = '0;
        end
      end
      S_RUN: begin
        cnt_d  = cnt_q + CNT_W'(1);
        done_d = done_q | hit;
        fail_d = fail_q | (hit & {NUM_HARTS{is_fail}});
        for (int unsigned i = 0; i < NUM_HARTS; i++) begin
          if (hit[i] && is_fail) code_d[i] = wr_data[XLEN-1:1];
        end
        // Completion is tested first so a final store on the timeout edge wins.
        if (&done_d)                state_d = S_DONE;
        else if (cnt_d == CNT_LIMIT) state_d = S_TIMEOUT;
      end
      S_DONE, S_TIMEOUT: begin
        if (clear) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      done_q    <= '0;
      fail_q    <= '0;
      rd_code_q <= '0;
      for (int unsigned i = 0; i < NUM_HARTS; i++) code_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
      rd_code_q <= rd_code_d;
      for (int unsigned i = 0; i < NUM_HARTS; i++) code_q[i] <= code_d[i];
    end
  end

  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign timeout     = (state_q == S_TIMEOUT);
  assign pass        = done && !(|fail_q);
  assign hart_done   = done_q;
  assign hart_fail   = fail_q;
  assign rd_code     = rd_code_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_pito_test_monitor.sv
// Bench for pito_test_monitor: directed vector table, hand sequences for the
// timeout/done boundary and async reset, then random traffic against a model.
module tb_pito_test_monitor;

  localparam int unsigned NH = 4;
  localparam int unsigned TO = 20;
  localparam logic [31:0] TA = 32'h0000_1000;

  logic        clk, rst_n, start, clear, wr_en;
  logic [1:0]  wr_hart, rd_hart;
  logic [31:0] wr_addr, wr_data;
  logic [30:0] rd_code;
  logic [3:0]  hart_done, hart_fail;
  logic        busy, done, pass, timeout;
  logic [31:0] cycle_count;

  int checks = 0;
  int failures = 0;

  pito_test_monitor #(
    .NUM_HARTS(NH), .XLEN(32), .TOHOST_ADDR(TA), .TIMEOUT_CYCLES(TO), .CNT_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .wr_en(wr_en),
    .wr_hart(wr_hart), .wr_addr(wr_addr), .wr_data(wr_data), .rd_hart(rd_hart),
    .rd_code(rd_code), .hart_done(hart_done), .hart_fail(hart_fail),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic st, cl, we; logic [1:0] wh; logic [31:0] wa, wd; logic [1:0] rh;
    logic bz, dn, ps, to; logic [3:0] hd, hf; logic [31:0] cc; logic [30:0] rc;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(logic st, logic cl, logic we, logic [1:0] wh,
                              logic [31:0] wa, logic [31:0] wd, logic [1:0] rh,
                              logic bz, logic dn, logic ps, logic to,
                              logic [3:0] hd, logic [3:0] hf, logic [31:0] cc,
                              logic [30:0] rc);
    vec_t v;
    v.st = st; v.cl = cl; v.we = we; v.wh = wh; v.wa = wa; v.wd = wd; v.rh = rh;
    v.bz = bz; v.dn = dn; v.ps = ps; v.to = to; v.hd = hd; v.hf = hf;
    v.cc = cc; v.rc = rc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic cl, input logic we, input logic [1:0] wh,
                       input logic [31:0] wa, input logic [31:0] wd, input logic [1:0] rh);
    start = st; clear = cl; wr_en = we; wr_hart = wh; wr_addr = wa; wr_data = wd; rd_hart = rh;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string nm, input logic bz, input logic dn, input logic ps,
                           input logic to, input logic [3:0] hd, input logic [3:0] hf,
                           input logic [31:0] cc);
    chk({nm, " busy"}, 64'(busy), 64'(bz));
    chk({nm, " done"}, 64'(done), 64'(dn));
    chk({nm, " pass"}, 64'(pass), 64'(ps));
    chk({nm, " timeout"}, 64'(timeout), 64'(to));
    chk({nm, " hart_done"}, 64'(hart_done), 64'(hd));
    chk({nm, " hart_fail"}, 64'(hart_fail), 64'(hf));
    chk({nm, " cycle_count"}, 64'(cycle_count), 64'(cc));
  endtask

  // Behavioural reference: run phase flags, per-hart arrays, plain counter.
  bit          m_run, m_fin, m_to;
  int unsigned m_cc;
  bit          m_hd [NH];
  bit          m_hf [NH];
  logic [30:0] m_code [NH];
  logic [30:0] m_rc;

  task automatic model_reset();
    m_run = 0; m_fin = 0; m_to = 0; m_cc = 0; m_rc = '0;
    for (int i = 0; i < NH; i++) begin m_hd[i] = 0; m_hf[i] = 0; m_code[i] = '0; end
  endtask

  task automatic model_step();
    bit all;
    m_rc = m_code[rd_hart];
    if (m_run) begin
      m_cc++;
      if (wr_en && wr_addr == TA && wr_data[0] && !m_hd[wr_hart]) begin
        m_hd[wr_hart] = 1;
        if (wr_data != 32'd1) begin
          m_hf[wr_hart] = 1;
          m_code[wr_hart] = wr_data[31:1];
        end
      end
      all = 1;
      for (int i = 0; i < NH; i++) if (!m_hd[i]) all = 0;
      if (all) begin m_run = 0; m_fin = 1; end
      else if (m_cc == TO) begin m_run = 0; m_to = 1; end
    end else if (m_fin || m_to) begin
      if (clear) begin m_fin = 0; m_to = 0; end
    end else if (start) begin
      m_run = 1; m_cc = 0;
      for (int i = 0; i < NH; i++) begin m_hd[i] = 0; m_hf[i] = 0; m_code[i] = '0; end
    end
  endtask

  function automatic logic [3:0] pack4(input bit a [NH]);
    logic [3:0] v;
    for (int i = 0; i < NH; i++) v[i] = a[i];
    return v;
  endfunction

  initial begin
    tbl[0]  = mk(0,0,1,0,TA,1,0,          0,0,0,0, 4'h0,4'h0,0,0);
    tbl[1]  = mk(1,0,0,0,TA,0,0,          1,0,0,0, 4'h0,4'h0,0,0);
    tbl[2]  = mk(0,0,1,0,TA,1,0,          1,0,0,0, 4'h1,4'h0,1,0);
    tbl[3]  = mk(0,0,1,1,TA,1,0,          1,0,0,0, 4'h3,4'h0,2,0);
    tbl[4]  = mk(0,0,1,2,TA,1,0,          1,0,0,0, 4'h7,4'h0,3,0);
    tbl[5]  = mk(0,0,1,3,TA,1,0,          0,1,1,0, 4'hF,4'h0,4,0);
    tbl[6]  = mk(1,0,1,0,TA,3,0,          0,1,1,0, 4'hF,4'h0,4,0);
    tbl[7]  = mk(0,1,0,0,TA,0,0,          0,0,0,0, 4'hF,4'h0,4,0);
    tbl[8]  = mk(0,0,0,0,TA,0,0,          0,0,0,0, 4'hF,4'h0,4,0);
    tbl[9]  = mk(1,0,0,0,TA,0,0,          1,0,0,0, 4'h0,4'h0,0,0);
    tbl[10] = mk(0,0,1,0,TA,1,2,          1,0,0,0, 4'h1,4'h0,1,0);
    tbl[11] = mk(0,0,1,2,TA,32'hB,2,      1,0,0,0, 4'h5,4'h4,2,0);
    tbl[12] = mk(0,0,1,1,TA,1,2,          1,0,0,0, 4'h7,4'h4,3,5);
    tbl[13] = mk(0,0,1,3,TA,2,2,          1,0,0,0, 4'h7,4'h4,4,5);
    tbl[14] = mk(0,0,1,3,TA+32'd4,1,2,    1,0,0,0, 4'h7,4'h4,5,5);
    tbl[15] = mk(0,0,1,0,TA,7,0,          1,0,0,0, 4'h7,4'h4,6,0);
    tbl[16] = mk(0,0,1,3,TA,1,2,          0,1,0,0, 4'hF,4'h4,7,5);
    tbl[17] = mk(0,1,0,0,TA,0,2,          0,0,0,0, 4'hF,4'h4,7,5);

    rst_n = 1'b0;
    drive(0,0,0,0,TA,0,0);
    repeat (3) @(posedge clk);
    #1;
    chk_flags("reset", 0,0,0,0, 4'h0,4'h0,0);
    chk("reset rd_code", 64'(rd_code), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < 18; r++) begin
      drive(tbl[r].st, tbl[r].cl, tbl[r].we, tbl[r].wh, tbl[r].wa, tbl[r].wd, tbl[r].rh);
      tick();
      chk_flags($sformatf("row%0d", r), tbl[r].bz, tbl[r].dn, tbl[r].ps, tbl[r].to,
                tbl[r].hd, tbl[r].hf, tbl[r].cc);
      chk($sformatf("row%0d rd_code", r), 64'(rd_code), 64'(tbl[r].rc));
    end

    // Timeout: only harts 0..2 complete.
    drive(1,0,0,0,TA,0,0); tick();
    chk_flags("to start", 1,0,0,0, 4'h0,4'h0,0);
    for (int k = 1; k <= 20; k++) begin
      if (k <= 3) drive(0,0,1,2'(k-1),TA,1,0);
      else        drive(0,0,0,0,TA,0,0);
      tick();
      if (k == 19) chk_flags("to edge19", 1,0,0,0, 4'h7,4'h0,19);
      if (k == 20) chk_flags("to edge20", 0,0,0,1, 4'h7,4'h0,20);
    end
    drive(1,0,1,3,TA,1,0); tick();
    chk_flags("to hold", 0,0,0,1, 4'h7,4'h0,20);
    drive(0,1,0,0,TA,0,0); tick();
    chk_flags("to clear", 0,0,0,0, 4'h7,4'h0,20);

    // Final completion on the timeout edge: DONE wins.
    drive(1,0,0,0,TA,0,0); tick();
    for (int k = 1; k <= 20; k++) begin
      if (k <= 3)       drive(0,0,1,2'(k-1),TA,1,0);
      else if (k == 20) drive(0,0,1,3,TA,1,0);
      else              drive(0,0,0,0,TA,0,0);
      tick();
    end
    chk_flags("race", 0,1,1,0, 4'hF,4'h0,20);
    drive(0,1,0,0,TA,0,0); tick();
    chk_flags("race clear", 0,0,0,0, 4'hF,4'h0,20);
    drive(1,0,0,0,TA,0,0); tick();
    chk_flags("restart", 1,0,0,0, 4'h0,4'h0,0);

    // Asynchronous reset in the middle of a run.
    drive(0,0,1,1,TA,32'h21,1); tick();
    drive(0,0,0,0,TA,0,1); tick();
    chk("prerst rd_code", 64'(rd_code), 64'h10);
    chk_flags("prerst", 1,0,0,0, 4'h2,4'h2,2);
    #2 rst_n = 1'b0;
    #1;
    chk_flags("async rst", 0,0,0,0, 4'h0,4'h0,0);
    chk("async rst rd_code", 64'(rd_code), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0,0,1,0,TA,1,0); tick(); tick();
    chk_flags("post rst idle", 0,0,0,0, 4'h0,4'h0,0);

    // Random traffic against the reference model.
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 800; n++) begin
      logic [31:0] d;
      case ($urandom_range(0, 3))
        0, 1: d = 32'd1;
        2:    d = $urandom() | 32'd1;
        default: d = $urandom() & ~32'd1;
      endcase
      drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0) ? TA + 32'd4 : TA, d,
            2'($urandom_range(0, 3)));
      model_step();
      tick();
      chk_flags($sformatf("rnd%0d", n), m_run, m_fin, m_fin && (pack4(m_hf) == 4'h0), m_to,
                pack4(m_hd), pack4(m_hf), m_cc);
      chk($sformatf("rnd%0d rd_code", n), 64'(rd_code), 64'(m_rc));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
